clk_src_switch_ctrl: RTL and testbench



---
 rtl/clk_src_switch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_clk_src_switch_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_src_switch_ctrl.sv
// rtl/clk_src_switch_ctrl.sv - glitch-free clock source switch sequencer
//
// Owns the clock-override select and the output-clock gate. A switch is
// gate off, settle, flip select, wait for PLL lock (PLL target only),
// settle, gate on. Runs on the always-on reference clock.
// Optional feature macro: LOCK_FALLBACK_EN (on lock timeout, fall back to
// the override source and re-open the gate instead of staying gated).
//
// Ports:
//   clock, reset_n       always-on reference clock, async active-low reset
//   req_valid/req_src    switch request (src 1 = override, 0 = PLL)
//   req_ready            high only in IDLE
//   pll_lock             raw asynchronous PLL lock
//   clk_over             registered select to the clock mux
//   clk_gate_en          registered output-clock enable
//   done                 one-cycle pulse when a request completes
//   lock_err             sticky lock timeout flag
//   lock_lost            sticky lock-drop-while-running-on-PLL flag
//   busy                 sequencer not in IDLE
module clk_src_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter logic        RESET_SRC     = 1'b1,
  parameter int unsigned CNT_W         = 11
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req_valid,
  input  logic req_src,
  output logic req_ready,
  input  logic pll_lock,
  output logic clk_over,
  output logic clk_gate_en,
  output logic done,
  output logic lock_err,
  output logic lock_lost,
  output logic busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE_OFF,
    ST_SWITCH,
    ST_WAIT_LOCK,
    ST_SETTLE_ON,
    ST_GATE_ON,
    ST_FAIL
  } state_t;

  // Counter is cleared on state entry, so the Nth cycle in a state sees N-1.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_q, src_d;
  logic             clk_over_q, clk_over_d;
  logic             clk_gate_en_q, clk_gate_en_d;
  logic             done_q, done_d;
  logic             lock_err_q, lock_err_d;
  logic             lock_lost_q, lock_lost_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;
  logic             lock_prev_q, lock_prev_d;
  logic             accept;

  assign accept = req_valid && (state_q == ST_IDLE);

  always_comb begin
    lock_meta_d   = pll_lock;
    lock_s_d      = lock_meta_q;
    lock_prev_d   = lock_s_q;
    state_d       = state_q;
    src_d         = src_q;
    clk_over_d    = clk_over_q;
    clk_gate_en_d = clk_gate_en_q;
    done_d        = 1'b0;
    lock_err_d    = lock_err_q;
    lock_lost_d   = lock_lost_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src_d       = req_src;
          lock_err_d  = 1'b0;
          lock_lost_d = 1'b0;
          if (req_src == clk_over_q) begin
            done_d = 1'b1;
          end else begin
            clk_gate_en_d = 1'b0;
            state_d       = ST_GATE_OFF;
          end
        end else if (!clk_over_q && clk_gate_en_q && lock_prev_q && !lock_s_q) begin
          lock_lost_d = 1'b1;
        end
      end
      ST_GATE_OFF: begin
        if (cnt_q >= SETTLE_LAST) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        clk_over_d = src_q;
        state_d    = src_q ? ST_SETTLE_ON : ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock arriving in the timeout cycle still counts as success.
        if (lock_s_q) begin
          state_d = ST_SETTLE_ON;
        end else if (cnt_q >= LOCK_LAST) begin
          lock_err_d = 1'b1;
          state_d    = ST_FAIL;
        end
      end
      ST_SETTLE_ON: begin
        if (cnt_q >= SETTLE_LAST) state_d = ST_GATE_ON;
      end
      ST_GATE_ON: begin
        clk_gate_en_d = 1'b1;
        done_d        = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_FAIL: begin
`ifdef LOCK_FALLBACK_EN
        // Move back to the reference clock while still gated, then settle.
        clk_over_d = 1'b1;
        if (cnt_q >= SETTLE_LAST) begin
          clk_gate_en_d = 1'b1;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end
`else
        // Stay on the dead PLL with the gate closed until a later request.
        done_d  = 1'b1;
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      src_q         <= RESET_SRC;
      clk_over_q    <= RESET_SRC;
      clk_gate_en_q <= 1'b1;
      done_q        <= 1'b0;
      lock_err_q    <= 1'b0;
      lock_lost_q   <= 1'b0;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      lock_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      src_q         <= src_d;
      clk_over_q    <= clk_over_d;
      clk_gate_en_q <= clk_gate_en_d;
      done_q        <= done_d;
      lock_err_q    <= lock_err_d;
      lock_lost_q   <= lock_lost_d;
      lock_meta_q   <= lock_meta_d;
      lock_s_q      <= lock_s_d;
      lock_prev_q   <= lock_prev_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign clk_over    = clk_over_q;
  assign clk_gate_en = clk_gate_en_q;
  assign done        = done_q;
  assign lock_err    = lock_err_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_clk_src_switch_ctrl.sv
// tb/tb_clk_src_switch_ctrl.sv - scoreboard bench for clk_src_switch_ctrl
module tb_clk_src_switch_ctrl;

  localparam int S  = 8;
  localparam int TO = 1024;
`ifdef LOCK_FALLBACK_EN
  localparam bit FALLBACK = 1'b1;
`else
  localparam bit FALLBACK = 1'b0;
`endif

  logic clock     = 1'b0;
  logic reset_n   = 1'b0;
  logic req_valid = 1'b0;
  logic req_src   = 1'b0;
  logic pll_lock  = 1'b0;
  logic req_ready, clk_over, clk_gate_en, done, lock_err, lock_lost, busy;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    int acc_edge;
    int latency;
    bit over;
    bit gate;
    bit err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model state: what the select and gate should be once idle.
  bit m_over = 1'b1;
  bit m_gate = 1'b1;

  bit early_pending = 1'b0;
  bit early_src     = 1'b0;
  int early_exp_a   = 0;

  clk_src_switch_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_src    (req_src),
    .req_ready  (req_ready),
    .pll_lock   (pll_lock),
    .clk_over   (clk_over),
    .clk_gate_en(clk_gate_en),
    .done       (done),
    .lock_err   (lock_err),
    .lock_lost  (lock_lost),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_latency", edge_cnt - mon_e.acc_edge + 1, mon_e.latency);
        check("clk_over_at_done", clk_over, mon_e.over);
        check("gate_at_done", clk_gate_en, mon_e.gate);
        check("lock_err_at_done", lock_err, mon_e.err);
        check("lock_lost_at_done", lock_lost, 0);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((busy || sb_q.size() != 0) && k < 4000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 4000) check("idle_timeout", 1, 0);
  endtask

  // mode 0: lock rises d cycles after the select flips; 1: already locked;
  // 2: lock never comes.
  task automatic run_txn(input bit src, input int mode, input int d,
                         input bit want_early, input bit next_src);
    int  a;
    int  ws;
    int  r;
    int  w;
    bit  got;
    bit  old;
    exp_t e;
    r = 0;
    if (!early_pending) begin
      wait_idle();
      if (src == 1'b0 && m_over == 1'b1) begin
        pll_lock = (mode == 1);
        r = edge_cnt;
        repeat (4) @(negedge clock);
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      req_valid = 1'b1;
      req_src   = src;
    end
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (req_ready) got = 1'b1;
      else @(negedge clock);
    end
    if (!got) begin
      check("accept_timeout", 1, 0);
      req_valid     = 1'b0;
      early_pending = 1'b0;
      return;
    end
    a = edge_cnt + 1;
    if (early_pending) check("held_req_accept_edge", a, early_exp_a);
    early_pending = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;

    old          = m_over;
    e.acc_edge   = a;
    if (src == m_over) begin
      e.latency = 1; e.over = m_over; e.gate = m_gate; e.err = 1'b0;
    end else if (src == 1'b1) begin
      e.latency = 2 * S + 3; e.over = 1'b1; e.gate = 1'b1; e.err = 1'b0;
    end else begin
      // Lock is seen internally two edges after the raw input changes.
      ws = a + S + 1;
      if (mode == 2) w = TO + 1;
      else begin
        if (mode == 0) r = ws + d;
        w = (r + 2) - ws + 1;
        if (w < 1) w = 1;
      end
      if (w <= TO) begin
        e.latency = 2 * S + 3 + w; e.over = 1'b0; e.gate = 1'b1; e.err = 1'b0;
      end else if (FALLBACK) begin
        e.latency = S + TO + S + 2; e.over = 1'b1; e.gate = 1'b1; e.err = 1'b1;
      end else begin
        e.latency = S + TO + 3; e.over = 1'b0; e.gate = 1'b0; e.err = 1'b1;
      end
    end
    sb_q.push_back(e);
    m_over = e.over;
    m_gate = e.gate;

    if (src != old) begin
      @(negedge clock);
      check("gate_off_after_accept", clk_gate_en, 0);
      check("ready_low_when_busy", req_ready, 0);
      repeat (S) @(negedge clock);
      check("select_held_before_switch", clk_over, old);
      @(negedge clock);
      check("select_flipped", clk_over, src);
      if (src == 1'b0 && mode == 0) begin
        repeat (d) @(negedge clock);
        pll_lock = 1'b1;
      end
      if (want_early && (next_src == 1'b1 || next_src == m_over)) begin
        req_valid     = 1'b1;
        req_src       = next_src;
        early_src     = next_src;
        early_pending = 1'b1;
        early_exp_a   = a + e.latency;
      end
    end
  endtask

  initial begin
    bit s;
    bit we;
    bit ns;
    int mode;
    int d;
    int rr;

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_clk_over", clk_over, 1);
    check("rst_gate", clk_gate_en, 1);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lock_err", lock_err, 0);
    check("rst_lock_lost", lock_lost, 0);

    run_txn(1'b1, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 0, 5, 1'b0, 1'b0);
    wait_idle();

    @(negedge clock);
    pll_lock = 1'b0;
    @(negedge clock);
    check("lock_lost_not_yet", lock_lost, 0);
    repeat (2) @(negedge clock);
    check("lock_lost_set", lock_lost, 1);
    pll_lock = 1'b1;
    repeat (4) @(negedge clock);
    check("lock_lost_sticky", lock_lost, 1);
    run_txn(1'b0, 0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 2, 0, 1'b0, 1'b0);
    run_txn(1'b1, 0, 0, 1'b1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      s    = early_pending ? early_src : 1'($urandom_range(0, 1));
      rr   = $urandom_range(0, 99);
      mode = (rr < 25) ? 1 : ((rr < 28) ? 2 : 0);
      d    = $urandom_range(0, 15);
      we   = ($urandom_range(0, 3) == 0);
      ns   = 1'($urandom_range(0, 1));
      run_txn(s, mode, d, we, ns);
    end
    if (early_pending) run_txn(early_src, 0, 0, 1'b0, 1'b0);
    wait_idle();

    if (m_over == 1'b0) run_txn(1'b1, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 1, 0, 1'b0, 1'b0);
    wait_idle();
    @(negedge clock);
    req_valid = 1'b1;
    req_src   = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_busy", busy, 1);
    check("mid_gate_off", clk_gate_en, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_clk_over", clk_over, 1);
    check("async_rst_gate", clk_gate_en, 1);
    check("async_rst_ready", req_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    m_over = 1'b1;
    m_gate = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run_txn(1'b0, 0, 3, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
